digit_argmax: RTL
=================

# digit_argmax

Classification stage of the hardware digit classifier. It sits directly downstream of the ten per-class neuron accumulators and captures each 26-bit signed class score as that accumulator pulses its valid. Once all ten scores are held, it serially scans them for the maximum and emits the winning digit index with a one-cycle valid pulse.

## Interface

Parameters:
- `NUM_CLASSES`, default 10: number of class lanes (2..16).
- `WIDTH`, default 26: score width, two's complement signed.
- `IDX_W`, default 4: class index width; must satisfy 2^IDX_W >= NUM_CLASSES.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-high.
- `in_valid`  in  NUM_CLASSES: per-lane capture strobe; bit i comes from neuron i's valid pulse.
- `in_data`  in  NUM_CLASSES*WIDTH: lane i score at `[WIDTH*i +: WIDTH]`.
- `out_valid`  out  1: one-cycle pulse; `out_class` is new this cycle.
- `out_class`  out  IDX_W: winning class index; held until the next result.
- `busy`  out  1: high in SCAN and DONE.
- `overrun`  out  1: sticky; a strobe arrived while it could not be accepted.
- `out_score`  out  WIDTH: winning score; present only with `DIGIT_ARGMAX_SCORE_OUT_EN`.

## Operation

- **States:** COLLECT, SCAN, DONE. Reset state is COLLECT.
- **COLLECT:**
  - For every i with `in_valid[i]`=1, `score[i]` <= lane i data and `got[i]` <= 1.
  - Several lanes may capture on the same edge.
  - A repeat strobe on an already-captured lane overwrites its score (last value wins); this is not an overrun.
- **Transition to SCAN:** on the edge E where `got` becomes all-ones, counting lanes captured on that edge:
  - state <= SCAN, `best_idx` <= 0, `best_score` <= `score[0]`, `ptr` <= 1.
  - If lane 0 is captured on edge E itself, the lane-0 value from `in_data` is used.
- **SCAN:** one comparison per edge.
  - If `score[ptr]` > `best_score` (signed, strictly greater), then `best_idx` <= `ptr` and `best_score` <= `score[ptr]`.
  - `ptr` increments each edge.
  - The edge that compares `ptr` = NUM_CLASSES-1 moves state to DONE.
- **Ties:** the lowest index wins.
- **DONE:** for one cycle. On its edge:
  - `out_valid` <= 1, `out_class` <= `best_idx`.
  - `got` <= 0, state <= COLLECT.
- **Strobes while busy:** any `in_valid` bit high during SCAN or DONE is ignored and sets `overrun` to 1. The scores under scan are never modified.
- **Overflow:** none possible. The block only compares, and all comparisons are full WIDTH signed.

## Timing

- **Reset values:** `out_valid`=0, `out_class`=0, `busy`=0, `overrun`=0, `out_score`=0.
  - Internal: state=COLLECT, `got`=0, `ptr`=0, `best_idx`=0, `best_score`=0.
  - `score[]` is don't-care after reset.
- **Latency:** `out_valid` is high in the cycle after edge E+NUM_CLASSES, where E is the final-capture edge. That is 10 edges for the default.
- **`busy`:** high from the cycle after edge E through the DONE cycle, i.e. NUM_CLASSES cycles.
- **Back-to-back:** the cycle in which `out_valid` is high is already COLLECT. Strobes arriving in that cycle are captured, so the next image may begin immediately.
- **Reset mid-scan:** `rst` during SCAN or DONE aborts the result and forces all reset values. No `out_valid` is produced for that image.
- **Reset priority:** `rst` has priority over capture on the same edge.

## Configuration

- **`DIGIT_ARGMAX_SCORE_OUT_EN` defined:**
  - Port `out_score` exists.
  - It loads `best_score` on the DONE edge, together with `out_class`, and holds it until the next result.
- **Not defined:**
  - Port `out_score` is absent.
  - `best_score` is used only internally; all other behaviour is identical.

## Test plan

- **Distinct scores, staggered arrival:** lanes strobed one per cycle in order 0..9 with scores 100, 250, -5, 900, 40, 899, 0, 3, 7, 12 -> `out_valid` pulse 10 cycles after lane 9's capture edge, `out_class`=3, `out_score`=900, `overrun`=0.
- **All negative, simultaneous arrival:** all ten strobed on one edge with scores -1000+i, except lane 7 = -2 -> `out_class`=7; confirms signed compare. Then all lanes 0 -> `out_class`=0 (tie rule).
- **Tie and overwrite:** lanes 2 and 8 both 500; lane 8 strobed twice, 600 then 500 -> `out_class`=2, `overrun`=0.
- **Overrun:** during SCAN, strobe lane 4 with 0x1FFFFFF -> `overrun`=1 and stays 1. Result is unchanged from the originally captured scores. The next image in COLLECT still classifies correctly.
- **Back-to-back:** second image fully strobed starting in the `out_valid` cycle -> second `out_valid` exactly 11 cycles after the first (one capture cycle plus 10). Both classes are correct.
- **Reset mid-scan:** assert `rst` 4 cycles into SCAN -> `out_valid` never pulses for that image and all outputs return to 0. A subsequent full image is classified normally.

Source files
------------

// File: rtl/digit_argmax.sv
// digit_argmax: captures NUM_CLASSES signed scores, scans them serially for the maximum, pulses the winner.
// Optional macro DIGIT_ARGMAX_SCORE_OUT_EN adds out_score, the winning score loaded alongside out_class.
module digit_argmax #(
   parameter int NUM_CLASSES = 10,
   parameter int WIDTH       = 26,
   parameter int IDX_W       = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_CLASSES-1:0]       in_valid,
   input  logic [NUM_CLASSES*WIDTH-1:0] in_data,
   output logic                         out_valid,
   output logic [IDX_W-1:0]             out_class,
   output logic                         busy,
   output logic                         overrun
`ifdef DIGIT_ARGMAX_SCORE_OUT_EN
   ,
   output logic [WIDTH-1:0]             out_score
`endif
);

   typedef enum logic [1:0] {COLLECT, SCAN, DONE} state_t;

   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CLASSES - 1);

   state_t                  state;
   logic signed [WIDTH-1:0] score [NUM_CLASSES];
   logic [NUM_CLASSES-1:0]  got;
   logic [NUM_CLASSES-1:0]  got_next;
   logic [IDX_W-1:0]        ptr;
   logic [IDX_W-1:0]        best_idx;
   logic signed [WIDTH-1:0] best_score;
   logic signed [WIDTH-1:0] lane0;

   assign got_next = got | in_valid;
   // Lane 0 may land on the same edge that completes the set; seed the scan with that fresh value.
   assign lane0    = in_valid[0] ? in_data[WIDTH-1:0] : score[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= COLLECT;
         got        <= '0;
         ptr        <= '0;
         best_idx   <= '0;
         best_score <= '0;
         out_valid  <= 1'b0;
         out_class  <= '0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
`ifdef DIGIT_ARGMAX_SCORE_OUT_EN
         out_score  <= '0;
`endif
      end else begin
         out_valid <= 1'b0;
         case (state)
            COLLECT: begin
               for (int i = 0; i < NUM_CLASSES; i++) begin
                  if (in_valid[i]) score[i] <= in_data[WIDTH*i +: WIDTH];
               end
               got <= got_next;
               if (&got_next) begin
                  state      <= SCAN;
                  busy       <= 1'b1;
                  best_idx   <= '0;
                  best_score <= lane0;
                  ptr        <= IDX_W'(1);
               end
            end
            SCAN: begin
               // Strictly greater keeps the lowest index on ties.
               if (score[ptr] > best_score) begin
                  best_idx   <= ptr;
                  best_score <= score[ptr];
               end
               ptr <= ptr + 1'b1;
               if (ptr == LAST) state <= DONE;
            end
            DONE: begin
               out_valid <= 1'b1;
               out_class <= best_idx;
`ifdef DIGIT_ARGMAX_SCORE_OUT_EN
               out_score <= best_score;
`endif
               got       <= '0;
               busy      <= 1'b0;
               state     <= COLLECT;
            end
            default: state <= COLLECT;
         endcase
         if (busy && (|in_valid)) overrun <= 1'b1;
      end
   end

endmodule
